// File: rtl/bip_addsub_pipe.sv
// bip_addsub_pipe: pipelined signed add/subtract unit with an accumulator.
// Stage 1 does all arithmetic (sum, carry, overflow, saturation) and updates
// the accumulator; later stages only delay {valid, z, carry, ovf}. A single
// global enable stalls every stage while the output is held by the consumer.
module bip_addsub_pipe #(
    parameter int WIDTH    = 11,
    parameter int STAGES   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] acc_out
);

    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_SUB      = 2'b01;
    localparam logic [1:0] OP_ACC_ADD  = 2'b10;
    localparam logic [1:0] OP_ACC_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    logic [WIDTH-1:0] r_acc;
    logic             r_vld   [STAGES];
    logic [WIDTH-1:0] r_z     [STAGES];
    logic             r_carry [STAGES];
    logic             r_ovf   [STAGES];

    assign w_en      = !r_vld[STAGES-1] || out_ready;
    assign in_ready  = w_en;
    assign w_accept  = in_valid && w_en;

    assign out_valid = r_vld[STAGES-1];
    assign z         = r_z[STAGES-1];
    assign carry     = r_carry[STAGES-1];
    assign ovf       = r_ovf[STAGES-1];
    assign zero      = (r_z[STAGES-1] == '0);
    assign acc_out   = r_acc;

    // Stage-1 arithmetic: pick effective operands, form the WIDTH+1 sum,
    // then derive carry/overflow and the (optionally clamped) result.
    // A same-cycle acc_clr makes accumulator ops see zero.
    always_comb begin
        w_acc_eff = acc_clr ? '0 : r_acc;
        w_x       = a;
        w_y       = b;
        w_cin     = 1'b0;
        case (op)
            OP_SUB: begin
                w_y   = ~b;
                w_cin = 1'b1;
            end
            OP_ACC_ADD: begin
                w_x = w_acc_eff;
                w_y = a;
            end
            default: ;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
        if (op == OP_ACC_LOAD) begin
            w_carry = 1'b0;
            w_ovf   = 1'b0;
            w_res   = a;
        end else begin
            w_carry = w_sum[WIDTH];
            w_ovf   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
            w_res   = w_sum[WIDTH-1:0];
            // On overflow the true result has the sign of the (equal-signed) operands.
            if (SATURATE && w_ovf) begin
                w_res = w_x[WIDTH-1] ? C_MIN : C_MAX;
            end
        end
    end

    // Accumulator: accepted acc ops write the new value; otherwise acc_clr zeroes it,
    // even while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept && op[1]) begin
            r_acc <= w_res;
        end else if (acc_clr) begin
            r_acc <= '0;
        end
    end

    // Pipeline registers: stage 0 captures the result, later stages delay it;
    // everything holds when the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i]   <= 1'b0;
                r_z[i]     <= '0;
                r_carry[i] <= 1'b0;
                r_ovf[i]   <= 1'b0;
            end
        end else if (w_en) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_z[0]     <= w_res;
                r_carry[0] <= w_carry;
                r_ovf[0]   <= w_ovf;
            end
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_z[i]     <= r_z[i-1];
                r_carry[i] <= r_carry[i-1];
                r_ovf[i]   <= r_ovf[i-1];
            end
        end
    end

endmodule

// File: doc/bip_addsub_pipe.md
Name: bip_addsub_pipe

Overview:
Parametrised, pipelined signed add/subtract unit with an internal accumulator, for the BIP datapath. It is the next generation of the fixed-width combinational adder. Adds selectable width and latency, subtract, accumulator ops, optional saturation, status flags and a valid/ready handshake with backpressure. It sits between the decode/operand stage and the writeback/accumulator path.

Parameters:
WIDTH, 11, operand/result width in bits, two's complement; legal range 4..32.
STAGES, 2, input-accept to out_valid latency in cycles; legal range 1..4.
SATURATE, 0, 1 = clamp on signed overflow; 0 = wrap.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand/op presented.
in_ready  out  1  unit can accept this cycle.
op  in  2  00 ADD a+b; 01 SUB a-b; 10 ACC_ADD acc+a; 11 ACC_LOAD acc=a.
a  in  WIDTH  operand A, signed.
b  in  WIDTH  operand B, signed; ignored for op 10/11.
acc_clr  in  1  synchronous accumulator clear.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
z  out  WIDTH  signed result.
carry  out  1  unsigned carry-out. For SUB, carry-out of a+~b+1, so 1 = no borrow. 0 for ACC_LOAD.
ovf  out  1  signed overflow of the operation, before saturation.
zero  out  1  z == 0.
acc_out  out  WIDTH  current accumulator register.

Behaviour:
- Reset (rst_n low, async): all stage valids 0; z, carry, ovf, acc_out = 0; zero = 1 (z == 0); in_ready = 1 after release.
- Accept = in_valid && in_ready. Pipeline advance enable en = !out_valid || out_ready. in_ready = en (combinational).
- Stage 1 computes in full: WIDTH+1-bit sum for carry; ovf = operands same sign and result sign differs, using the effective operands.
- Stages 2..STAGES are pure delay registers carrying {valid, z, carry, ovf}. zero is derived from registered z.
- Hold: when en = 0, every stage holds and out_* stay stable. No drop or duplication.
- Bubbles are allowed when in_valid = 0: stage valid = 0 propagates.
- Saturation: SATURATE = 1 and ovf = 1 clamps z to +(2^(WIDTH-1)-1) if the true result is positive, else -2^(WIDTH-1). ovf stays 1. carry is unaffected.
- Accumulator:
  - Updated only on accept with op 10/11, or by acc_clr.
  - ACC_ADD: acc <= acc+a, with the same wrap/saturate rule. ACC_LOAD: acc <= a.
  - z for an acc op equals the new acc value.
  - acc_out shows the register, so the new value appears the cycle after accept.
  - Back-to-back acc ops have no hazard, because the accumulator updates in stage 1.
- acc_clr same cycle as an accepted acc op: clear applies first, so the op sees acc = 0. With no acc op, acc <= 0.
- acc_clr while stalled: acc clears; ops already in flight are unaffected.
- ADD/SUB never modify acc.
- Reset mid-operation discards all in-flight results. No out_valid is asserted for them after release.
- Latency: accept at cycle N gives out_valid at cycle N+STAGES-1+1 = N+STAGES, provided no stall occurs.
- Full throughput: 1 result/cycle while out_ready = 1.

Test Plan:
1. WIDTH=11, SATURATE=0, ADD a=1000 b=100 -> z=-948 (0x44C), ovf=1, carry=0, zero=0.
2. SATURATE=1, same stimulus -> z=1023, ovf=1. Then ADD a=-1000 b=-100 -> z=-1024, ovf=1, carry=1.
3. SUB a=5 b=5 -> z=0, zero=1, carry=1, ovf=0. SUB a=3 b=5 -> z=-2, carry=0. STAGES=2: accept at cycle 0 gives out_valid at cycle 2.
4. Stream 8 ADDs (a=i, b=1) with out_ready low for cycles 3-5 -> in_ready low those cycles. Outputs are 1..8 in order, each once, and values hold stable while stalled.
5. ACC_LOAD 7, ACC_ADD 3, ACC_ADD -2 back-to-back -> z=7,10,8, acc_out=8. Then ACC_ADD 4 with acc_clr=1 -> z=4, acc_out=4.
6. Assert rst_n low with 2 results in flight -> out_valid=0 and acc_out=0 immediately. After release, no stale result appears, and the first new ADD 1+1 gives z=2.
